// File: rtl/sma_pkg.sv
// Shared types and constants for the SMA filter output path.
// Sample width, drop counter width and FIFO level sizing live here.
package sma_pkg;

    localparam int DATA_W = 16;
    localparam int DROP_W = 8;

    typedef logic signed [DATA_W-1:0] sma_sample_t;

    // Level must represent 0..depth inclusive, hence depth+1 states.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sma_sample_fifo.sv
// FWFT synchronous FIFO: a write appears on dout_o one cycle later when empty.
// Backpressure: a push into a full FIFO is ignored unless a pop happens in the same cycle.
module sma_sample_fifo
    import sma_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            din_i,
    output logic [WIDTH-1:0]            dout_o,
    output logic [level_w(DEPTH)-1:0]   level_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    // Full/empty come from the level count, so pointers may wrap freely.
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/sma_decim_fifo.sv
// Keeps every DECIM-th valid SMA sample and buffers it for a valid/ready consumer; 1-cycle push-to-out latency.
// Backpressure: when full without a pop, kept samples are dropped and counted (sticky overflow).
module sma_decim_fifo
    import sma_pkg::*;
#(
    parameter int DATA_W = sma_pkg::DATA_W,
    parameter int DECIM  = 4,
    parameter int DEPTH  = 4,
    parameter int DROP_W = sma_pkg::DROP_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic signed [DATA_W-1:0]    x,
    input  logic                        x_valid,
    output logic signed [DATA_W-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_cnt
);

    localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]   phase_q, phase_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              keep, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    assign keep = x_valid && (phase_q == PH_LAST);
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
    assign drop = keep && fifo_full && !pop && !clr;

    always_comb begin
        phase_d = phase_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (clr) begin
            phase_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (x_valid) phase_d = keep ? '0 : phase_q + 1'b1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    sma_sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clr),
        .push_i  (keep),
        .pop_i   (pop),
        .din_i   (x),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_data  = fifo_dout;
    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sma_decim_fifo.sv
// Directed bench: DECIM=4 and DECIM=1 instances share stimulus; each test checks one instance.
module tb_sma_decim_fifo;
    import sma_pkg::*;

    logic        clk;
    logic        rst;
    logic        clr;
    sma_sample_t x;
    logic        x_valid;
    logic        out_ready;

    sma_sample_t d4_data, d1_data;
    logic        d4_valid, d1_valid;
    logic [2:0]  d4_level, d1_level;
    logic        d4_ovf, d1_ovf;
    logic [7:0]  d4_drop, d1_drop;

    int n_checks = 0;
    int n_fail   = 0;

    int t2_val [8] = '{-5, 100, -6, 101, -7, 102, -8, 0};
    bit t2_vld [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    sma_decim_fifo #(.DECIM(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr), .x(x), .x_valid(x_valid),
        .out_data(d4_data), .out_valid(d4_valid), .out_ready(out_ready),
        .level(d4_level), .overflow(d4_ovf), .drop_cnt(d4_drop)
    );

    sma_decim_fifo #(.DECIM(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .x(x), .x_valid(x_valid),
        .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
        .level(d1_level), .overflow(d1_ovf), .drop_cnt(d1_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] u(input logic [15:0] v);
        return {16'd0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input bit vld);
        x       = sma_sample_t'(v);
        x_valid = vld;
        tick();
    endtask

    task automatic do_clr();
        clr     = 1'b1;
        x_valid = 1'b0;
        tick();
        clr     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; x = '0; x_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(d4_valid), 0);
        check("rst_level", 32'(d4_level), 0);
        check("rst_data",  u(d4_data), 0);
        check("rst_ovf",   32'(d4_ovf), 0);
        check("rst_drop",  32'(d4_drop), 0);
        rst = 1'b1;
        tick();

        // Continuous input: 4, 8, 12 each appear one cycle after their push edge.
        out_ready = 1'b1;
        do_clr();
        for (int i = 1; i <= 12; i++) begin
            feed(i, 1'b1);
            check("t1_valid", 32'(d4_valid), (i % 4 == 0) ? 1 : 0);
            check("t1_level", 32'(d4_level), (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 0) check("t1_data", u(d4_data), i);
        end
        feed(0, 1'b0);
        check("t1_drained", 32'(d4_valid), 0);

        // Gapped input: only the 4th valid sample (-8) is kept.
        do_clr();
        for (int i = 0; i < 8; i++) begin
            feed(t2_val[i], t2_vld[i]);
            check("t2_valid", 32'(d4_valid), (i == 6) ? 1 : 0);
            if (i == 6) check("t2_data", u(d4_data), 32'h0000_FFF8);
        end

        // Overflow on DECIM=1: six pushes into four slots, head held under backpressure.
        out_ready = 1'b0;
        do_clr();
        for (int k = 1; k <= 6; k++) begin
            feed(k * 10, 1'b1);
            check("t3_level", 32'(d1_level), (k > 4) ? 4 : k);
            check("t3_head",  u(d1_data), 10);
            check("t3_drop",  32'(d1_drop), (k > 4) ? k - 4 : 0);
            check("t3_ovf",   32'(d1_ovf), (k > 4) ? 1 : 0);
        end
        x_valid   = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check("t3_drain", u(d1_data), j * 10);
            tick();
        end
        check("t3_empty_valid", 32'(d1_valid), 0);
        check("t3_empty_data",  u(d1_data), 0);
        check("t3_ovf_sticky",  32'(d1_ovf), 1);
        check("t3_drop_final",  32'(d1_drop), 2);

        // Full FIFO with push and pop in the same cycle: nothing dropped.
        out_ready = 1'b0;
        do_clr();
        for (int k = 1; k <= 4; k++) feed(k, 1'b1);
        check("t4_full", 32'(d1_level), 4);
        out_ready = 1'b1;
        feed(5, 1'b1);
        x_valid = 1'b0;
        check("t4_level", 32'(d1_level), 4);
        check("t4_drop",  32'(d1_drop), 0);
        check("t4_ovf",   32'(d1_ovf), 0);
        for (int j = 2; j <= 5; j++) begin
            check("t4_drain", u(d1_data), j);
            tick();
        end
        check("t4_empty", 32'(d1_valid), 0);

        // clr beats a simultaneous push and pop.
        out_ready = 1'b0;
        do_clr();
        for (int i = 1; i <= 20; i++) feed(i, 1'b1);
        x_valid   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_level", 32'(d4_level), 3);
        check("t5_ovf",   32'(d4_ovf), 1);
        check("t5_drop",  32'(d4_drop), 1);
        check("t5_head",  u(d4_data), 8);
        for (int i = 21; i <= 23; i++) feed(i, 1'b1);
        check("t5_level_pre", 32'(d4_level), 3);
        clr = 1'b1; x = sma_sample_t'(24); x_valid = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0; x_valid = 1'b0; out_ready = 1'b0;
        check("t5_clr_level", 32'(d4_level), 0);
        check("t5_clr_valid", 32'(d4_valid), 0);
        check("t5_clr_data",  u(d4_data), 0);
        check("t5_clr_ovf",   32'(d4_ovf), 0);
        check("t5_clr_drop",  32'(d4_drop), 0);
        for (int i = 1001; i <= 1004; i++) begin
            feed(i, 1'b1);
            check("t5_after_valid", 32'(d4_valid), (i == 1004) ? 1 : 0);
        end
        check("t5_after_data", u(d4_data), 1004);

        // Asynchronous reset between edges, mid-burst.
        for (int i = 2001; i <= 2010; i++) feed(i, 1'b1);
        check("t6_level_pre", 32'(d4_level), 3);
        x = sma_sample_t'(2011);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(d4_valid), 0);
        check("t6_rst_level", 32'(d4_level), 0);
        check("t6_rst_data",  u(d4_data), 0);
        x_valid = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        for (int i = 2101; i <= 2104; i++) begin
            feed(i, 1'b1);
            check("t6_restart_valid", 32'(d4_valid), (i == 2104) ? 1 : 0);
        end
        check("t6_restart_data", u(d4_data), 2104);
        x_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
